// File: rtl/exec_pkg.sv
// Shared encodings for the run/step sequencer: FSM states, stop-reason codes
// and the default halt opcode.
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } seqState_t;

    typedef enum logic [1:0] {
        RSN_NONE  = 2'd0,
        RSN_USER  = 2'd1,
        RSN_BP    = 2'd2,
        RSN_COUNT = 2'd3
    } stopReason_t;

    localparam logic [5:0] DEF_HALT_OPCODE = 6'h3F;

endpackage

// File: rtl/exec_sequencer_if.sv
// Control/status bundle between the front-panel decode, the datapath and the
// run/step sequencer.
interface exec_sequencer_if #(
    parameter int COUNT_W = 16
);
    logic               stepReq;
    logic               runReq;
    logic               stopReq;
    logic [COUNT_W-1:0] runCount;
    logic               bpEnable;
    logic [31:0]        bpAddr;
    logic [31:0]        pcAddr;
    logic [5:0]         opcode;
    logic               execEnable;
    logic [1:0]         state;
    logic               running;
    logic [1:0]         stopReason;
    logic [COUNT_W-1:0] instrCount;

    modport master (
        output stepReq, runReq, stopReq, runCount, bpEnable, bpAddr, pcAddr, opcode,
        input  execEnable, state, running, stopReason, instrCount
    );

    modport slave (
        input  stepReq, runReq, stopReq, runCount, bpEnable, bpAddr, pcAddr, opcode,
        output execEnable, state, running, stopReason, instrCount
    );
endinterface

// File: rtl/exec_sequencer_issue_timer.sv
// Reloadable down-counter that paces run-mode issues; tick marks an issue point.
module issue_timer #(
    parameter int RUN_DIV = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic load,
    output logic tick
);
    localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DW-1:0] RELOAD = DW'(RUN_DIV - 1);

    logic [DW-1:0] divCnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)                divCnt <= '0;
        else if (load)           divCnt <= RELOAD;
        else if (divCnt != '0)   divCnt <= divCnt - DW'(1);
    end

    assign tick = (divCnt == '0);
endmodule

// File: rtl/exec_sequencer.sv
// Run/step controller: produces the one-cycle execEnable commit pulse for the
// single-cycle datapath and tracks why a run stopped.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int         RUN_DIV     = 4,
    parameter int         COUNT_W     = 16,
    parameter logic [5:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
    input logic             Clk,
    input logic             Rst,
    exec_sequencer_if.slave bus
);
    seqState_t          st, stNext;
    stopReason_t        reason, reasonNext;
    logic [COUNT_W-1:0] remaining, remainingNext, instrCount;
    logic               limited, limitedNext;
    logic               firstIssue, firstIssueNext;
    logic               stopPend, stopPendNext;
    logic               issue, load, tick, execEnable, running;
    logic               haltOp, bpHit, stopNow;

    issue_timer #(.RUN_DIV(RUN_DIV)) uTimer (
        .Clk  (Clk),
        .Rst  (Rst),
        .load (load),
        .tick (tick)
    );

    assign haltOp  = (bus.opcode == HALT_OPCODE);
    // The first issue of a run ignores the breakpoint so a run can resume from it.
    assign bpHit   = bus.bpEnable && (bus.pcAddr == bus.bpAddr) && !firstIssue;
    assign stopNow = stopPend || bus.stopReq;

    always_comb begin
        stNext         = st;
        reasonNext     = reason;
        remainingNext  = remaining;
        limitedNext    = limited;
        firstIssueNext = firstIssue;
        stopPendNext   = stopPend;
        issue          = 1'b0;
        load           = 1'b0;
        case (st)
            IDLE: begin
                if (bus.stepReq) begin
                    if (haltOp) begin
                        stNext = HALT;
                    end else begin
                        stNext     = STEP;
                        issue      = 1'b1;
                        reasonNext = RSN_NONE;
                    end
                end else if (bus.runReq) begin
                    stNext         = RUN;
                    load           = 1'b1;
                    remainingNext  = bus.runCount;
                    limitedNext    = (bus.runCount != '0);
                    firstIssueNext = 1'b1;
                    stopPendNext   = 1'b0;
                    reasonNext     = RSN_NONE;
                end
            end
            STEP: stNext = IDLE;
            RUN: begin
                stopPendNext = stopNow;
                if (tick) begin
                    stopPendNext = 1'b0;
                    if (stopNow) begin
                        stNext     = IDLE;
                        reasonNext = RSN_USER;
                    end else if (haltOp) begin
                        stNext = HALT;
                    end else if (bpHit) begin
                        stNext     = IDLE;
                        reasonNext = RSN_BP;
                    end else if (limited && remaining == '0) begin
                        stNext     = IDLE;
                        reasonNext = RSN_COUNT;
                    end else begin
                        issue          = 1'b1;
                        load           = 1'b1;
                        firstIssueNext = 1'b0;
                        if (remaining != '0) remainingNext = remaining - COUNT_W'(1);
                    end
                end
            end
            HALT:    stNext = HALT;
            default: stNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            st         <= IDLE;
            reason     <= RSN_NONE;
            execEnable <= 1'b0;
            running    <= 1'b0;
            remaining  <= '0;
            limited    <= 1'b0;
            firstIssue <= 1'b0;
            stopPend   <= 1'b0;
            instrCount <= '0;
        end else begin
            st         <= stNext;
            reason     <= reasonNext;
            execEnable <= issue;
            running    <= (stNext == RUN);
            remaining  <= remainingNext;
            limited    <= limitedNext;
            firstIssue <= firstIssueNext;
            stopPend   <= stopPendNext;
            if (execEnable && instrCount != '1) instrCount <= instrCount + COUNT_W'(1);
        end
    end

    assign bus.execEnable = execEnable;
    assign bus.state      = st;
    assign bus.running    = running;
    assign bus.stopReason = reason;
    assign bus.instrCount = instrCount;
endmodule

// File: tb/tb_exec_sequencer.sv
// Directed + randomized bench for exec_sequencer; pulse timing and counts are
// predicted arithmetically from the issue period and run length.
module tb_exec_sequencer;
    localparam int RUN_DIV = 4;
    localparam int COUNT_W = 4;
    localparam int CMAX    = (1 << COUNT_W) - 1;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    exec_sequencer_if #(.COUNT_W(COUNT_W)) bus ();

    exec_sequencer #(.RUN_DIV(RUN_DIV), .COUNT_W(COUNT_W), .HALT_OPCODE(6'h3F)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pulseCyc[$];
    int          modelCount = 0;
    logic        pcClr = 1'b1;
    logic [31:0] pcReg = '0;

    // Datapath stand-in: PC advances by 4 on every commit edge.
    always @(posedge Clk) cyc <= cyc + 1;
    always @(posedge Clk) begin
        if (pcClr) pcReg <= '0;
        else if (bus.execEnable === 1'b1) pcReg <= pcReg + 32'd4;
    end
    always @(negedge Clk) if (bus.execEnable === 1'b1) pulseCyc.push_back(cyc);
    assign bus.pcAddr = pcReg;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic int expCount();
        return (modelCount > CMAX) ? CMAX : modelCount;
    endfunction

    task automatic runCounted(input int rc);
        int base, n0;
        base = pulseCyc.size();
        bus.runCount = COUNT_W'(rc);
        bus.runReq = 1'b1;
        tick();
        bus.runReq = 1'b0;
        n0 = cyc;
        chk("run_state", 32'(bus.state), 32'd2);
        chk("run_running", 32'(bus.running), 32'd1);
        repeat ((rc + 1) * RUN_DIV + 2) tick();
        chk("run_pulses", 32'(pulseCyc.size() - base), 32'(rc));
        for (int k = 0; k < rc; k++)
            if (base + k < pulseCyc.size())
                chk("run_pulse_cyc", 32'(pulseCyc[base + k]), 32'(n0 + (k + 1) * RUN_DIV));
        chk("run_end_state", 32'(bus.state), 32'd0);
        chk("run_end_reason", 32'(bus.stopReason), 32'd3);
        chk("run_end_running", 32'(bus.running), 32'd0);
        modelCount += rc;
        chk("run_instrCount", 32'(bus.instrCount), 32'(expCount()));
    endtask

    initial begin
        int base, n0;
        bus.stepReq = 1'b0; bus.runReq = 1'b0; bus.stopReq = 1'b0;
        bus.runCount = '0; bus.bpEnable = 1'b0; bus.bpAddr = '0; bus.opcode = 6'h00;

        #1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_exec", 32'(bus.execEnable), 32'd0);
        chk("rst_running", 32'(bus.running), 32'd0);
        chk("rst_reason", 32'(bus.stopReason), 32'd0);
        chk("rst_count", 32'(bus.instrCount), 32'd0);
        repeat (3) tick();
        Rst = 1'b1; pcClr = 1'b0;
        tick();

        // single step
        base = pulseCyc.size();
        bus.stepReq = 1'b1; tick(); bus.stepReq = 1'b0;
        chk("step_exec", 32'(bus.execEnable), 32'd1);
        chk("step_state", 32'(bus.state), 32'd1);
        tick();
        chk("step_exec_off", 32'(bus.execEnable), 32'd0);
        chk("step_idle", 32'(bus.state), 32'd0);
        chk("step_pulses", 32'(pulseCyc.size() - base), 32'd1);
        modelCount += 1;
        chk("step_count", 32'(bus.instrCount), 32'(expCount()));

        // counted runs: fixed, then random lengths
        runCounted(3);
        for (int i = 0; i < 3; i++) runCounted(int'($urandom_range(1, 5)));

        // breakpoint at 0x0C from PC 0, unlimited run
        pcClr = 1'b1; tick(); pcClr = 1'b0;
        bus.bpEnable = 1'b1; bus.bpAddr = 32'h0C; bus.runCount = '0;
        base = pulseCyc.size();
        bus.runReq = 1'b1; tick(); bus.runReq = 1'b0;
        for (int i = 0; i < 40 && bus.running === 1'b1; i++) tick();
        chk("bp_pulses", 32'(pulseCyc.size() - base), 32'd3);
        chk("bp_reason", 32'(bus.stopReason), 32'd2);
        chk("bp_pc", pcReg, 32'h0C);
        chk("bp_state", 32'(bus.state), 32'd0);
        modelCount += 3;

        // resume from the breakpoint PC, then user stop one cycle after the pulse
        base = pulseCyc.size();
        bus.runReq = 1'b1; tick(); bus.runReq = 1'b0;
        n0 = cyc;
        for (int i = 0; i < 20 && bus.execEnable !== 1'b1; i++) tick();
        chk("resume_pulse", 32'(bus.execEnable), 32'd1);
        chk("resume_cyc", 32'(cyc), 32'(n0 + RUN_DIV));
        tick();
        bus.stopReq = 1'b1; tick(); bus.stopReq = 1'b0;
        repeat (RUN_DIV) tick();
        chk("stop_pulses", 32'(pulseCyc.size() - base), 32'd1);
        chk("stop_state", 32'(bus.state), 32'd0);
        chk("stop_reason", 32'(bus.stopReason), 32'd1);
        chk("stop_pc", pcReg, 32'h10);
        modelCount += 1;
        bus.bpEnable = 1'b0;

        // step and run requested together: step wins
        base = pulseCyc.size();
        bus.stepReq = 1'b1; bus.runReq = 1'b1; bus.runCount = 4'd2; tick();
        bus.stepReq = 1'b0; bus.runReq = 1'b0;
        chk("both_state", 32'(bus.state), 32'd1);
        chk("both_exec", 32'(bus.execEnable), 32'd1);
        repeat (3 * RUN_DIV) tick();
        chk("both_pulses", 32'(pulseCyc.size() - base), 32'd1);
        chk("both_idle", 32'(bus.state), 32'd0);
        modelCount += 1;

        // longest counted run pushes instrCount into saturation
        runCounted(CMAX);
        chk("sat_count", 32'(bus.instrCount), 32'(CMAX));

        // async reset while a pulse is high
        bus.runCount = '0;
        bus.runReq = 1'b1; tick(); bus.runReq = 1'b0;
        for (int i = 0; i < 20 && bus.execEnable !== 1'b1; i++) tick();
        chk("mid_pulse", 32'(bus.execEnable), 32'd1);
        #2 Rst = 1'b0;
        #1;
        chk("arst_exec", 32'(bus.execEnable), 32'd0);
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_running", 32'(bus.running), 32'd0);
        chk("arst_reason", 32'(bus.stopReason), 32'd0);
        chk("arst_count", 32'(bus.instrCount), 32'd0);
        base = pulseCyc.size();
        repeat (2 * RUN_DIV) tick();
        chk("arst_no_pulse", 32'(pulseCyc.size() - base), 32'd0);
        Rst = 1'b1; modelCount = 0;
        tick();

        // halt opcode at an issue point
        bus.opcode = 6'h3F; bus.runCount = 4'd2;
        base = pulseCyc.size();
        bus.runReq = 1'b1; tick(); bus.runReq = 1'b0;
        repeat (RUN_DIV + 2) tick();
        chk("halt_state", 32'(bus.state), 32'd3);
        chk("halt_running", 32'(bus.running), 32'd0);
        bus.opcode = 6'h00;
        bus.stepReq = 1'b1; tick(); bus.stepReq = 1'b0;
        bus.runReq = 1'b1; tick(); bus.runReq = 1'b0;
        repeat (2 * RUN_DIV) tick();
        chk("halt_hold", 32'(bus.state), 32'd3);
        chk("halt_no_pulse", 32'(pulseCyc.size() - base), 32'd0);
        chk("halt_reason", 32'(bus.stopReason), 32'd0);
        Rst = 1'b0; #1;
        chk("halt_rst_state", 32'(bus.state), 32'd0);
        chk("halt_rst_count", 32'(bus.instrCount), 32'd0);
        tick(); Rst = 1'b1; tick();

        // step onto a halt opcode from IDLE
        bus.opcode = 6'h3F;
        base = pulseCyc.size();
        bus.stepReq = 1'b1; tick(); bus.stepReq = 1'b0;
        tick();
        chk("step_halt_state", 32'(bus.state), 32'd3);
        chk("step_halt_pulse", 32'(pulseCyc.size() - base), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
